tff_updown_counter: RTL and testbench

//  Synchronous modulo-N up/down counter built as a bank of toggle (T) flip-flops.

---
 rtl/tff_updown_counter.sv | 81 ++++++++
 tb/tb_tff_updown_counter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/tff_updown_counter.sv
// Modulo-MODULUS up/down counter built from a bank of T stages.
// Exposes the toggle vector, the count, a terminal-count flag and a registered wrap pulse.
module tff_updown_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] t_out,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] dsat;
    logic [WIDTH-1:0] inc_t, dec_t;
    logic             run_hi, run_lo;
    logic             at_max, at_top, at_zero;

    // Ripple-carry / ripple-borrow toggle patterns for a plain binary step.
    always_comb begin
        inc_t  = '0;
        dec_t  = '0;
        run_hi = 1'b1;
        run_lo = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            inc_t[i] = run_hi;
            dec_t[i] = run_lo;
            run_hi   = run_hi & count_q[i];
            run_lo   = run_lo & ~count_q[i];
        end
    end

    always_comb begin
        dsat    = ({1'b0, d} < MOD_EXT) ? d : MAX_CNT;
        at_max  = (count_q == MAX_CNT);
        // A stray value above the range still wraps to 0 when counting up.
        at_top  = (count_q >= MAX_CNT);
        at_zero = (count_q == '0);

        t_out = '0;
        tc    = 1'b0;
        if (load) begin
            t_out = count_q ^ dsat;
        end else if (en) begin
            if (up) begin
                t_out = at_top ? count_q : inc_t;
                tc    = at_max;
            end else begin
                t_out = at_zero ? MAX_CNT : dec_t;
                tc    = at_zero;
            end
        end

        count_d = count_q ^ t_out;
        wrap_d  = tc;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_tff_updown_counter.sv
// Scoreboarded random/directed bench for the modulo T-stage counter.
// Expected values come from an integer modulo model of the counting rules.
module tb_tff_updown_counter;

    localparam int M = 10;

    logic       clk = 1'b0;
    logic       clr, en, up, load;
    logic [3:0] d, count, t_out;
    logic       tc, wrap;

    logic       clr2, en2, up2, load2;
    logic [0:0] d2, count2, t2;
    logic       tc2, wrap2;

    int total = 0;
    int bad   = 0;
    int m_cnt = 0;

    typedef struct {
        logic [3:0] c_next;
        logic [3:0] t;
        logic       tc;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    tff_updown_counter #(.WIDTH(4), .MODULUS(10)) dut (
        .clk(clk), .clr(clr), .en(en), .up(up), .load(load), .d(d),
        .count(count), .t_out(t_out), .tc(tc), .wrap(wrap)
    );

    tff_updown_counter #(.WIDTH(1), .MODULUS(2)) dut2 (
        .clk(clk), .clr(clr2), .en(en2), .up(up2), .load(load2), .d(d2),
        .count(count2), .t_out(t2), .tc(tc2), .wrap(wrap2)
    );

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: load saturates, hold keeps, up/down step modulo M.
    task automatic step(input logic ld, input logic e, input logic u, input logic [3:0] dv);
        exp_t x;
        int   nxt;
        @(negedge clk);
        load = ld; en = e; up = u; d = dv;
        if (ld)      nxt = (int'(dv) < M) ? int'(dv) : M - 1;
        else if (!e) nxt = m_cnt;
        else if (u)  nxt = (m_cnt + 1) % M;
        else         nxt = (m_cnt + M - 1) % M;
        x.c_next = nxt[3:0];
        x.t      = m_cnt[3:0] ^ nxt[3:0];
        x.tc     = !ld && e && (u ? (m_cnt == M - 1) : (m_cnt == 0));
        sb.push_back(x);
        m_cnt = nxt;
    endtask

    initial begin : monitor
        logic [3:0] pre_c, pre_t;
        logic       pre_tc;
        exp_t       x;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                pre_c  = count;
                pre_t  = t_out;
                pre_tc = tc;
                @(posedge clk);
                #1;
                x = sb.pop_front();
                check("t_out", int'(pre_t), int'(x.t));
                check("tc", int'(pre_tc), int'(x.tc));
                check("count", int'(count), int'(x.c_next));
                check("tff_xor", int'(count), int'(pre_c ^ pre_t));
                check("wrap", int'(wrap), int'(x.tc));
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int m2, nxt2;
        logic u2, exp_tc2;

        clr = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; d = '0;
        clr2 = 1'b1; en2 = 1'b0; up2 = 1'b0; load2 = 1'b0; d2 = '0;
        repeat (3) @(negedge clk);
        check("reset_count", int'(count), 0);
        check("reset_wrap", int'(wrap), 0);
        clr = 1'b0;

        // Up count through the 9->0 wrap, then on to 7.
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b1, 4'd0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 4'd0);

        // Asynchronous clear between edges, held over three edges.
        @(negedge clk);
        en = 1'b0;
        #3 clr = 1'b1;
        #1;
        check("clr_count", int'(count), 0);
        check("clr_wrap", int'(wrap), 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("clr_hold_count", int'(count), 0);
            check("clr_hold_wrap", int'(wrap), 0);
        end
        @(negedge clk);
        clr = 1'b0;
        m_cnt = 0;

        // Down wrap from 0, then a few more down steps.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 4'd0);

        // Load priority and saturation.
        step(1'b1, 1'b0, 1'b1, 4'd3);
        step(1'b1, 1'b1, 1'b1, 4'd6);
        step(1'b1, 1'b1, 1'b0, 4'd13);
        step(1'b1, 1'b1, 1'b1, 4'd9);
        step(1'b0, 1'b1, 1'b0, 4'd0);
        step(1'b0, 1'b1, 1'b1, 4'd0);

        // Hold at 5.
        step(1'b1, 1'b0, 1'b0, 4'd5);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));

        // Random traffic.
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));

        @(negedge clk);
        load = 1'b0; en = 1'b0;
        repeat (2) @(negedge clk);
        check("sb_drained", sb.size(), 0);

        // Modulo-2, one-bit instance: pure up, then direction chosen so every edge wraps.
        check("m2_reset_count", int'(count2), 0);
        clr2 = 1'b0;
        m2 = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            u2 = (k < 8) ? 1'b1 : (m2 == 1);
            en2 = 1'b1; up2 = u2;
            nxt2 = u2 ? (m2 + 1) % 2 : (m2 + 1) % 2;
            exp_tc2 = u2 ? (m2 == 1) : (m2 == 0);
            #1;
            check("m2_t_out", int'(t2), m2 ^ nxt2);
            check("m2_tc", int'(tc2), int'(exp_tc2));
            @(posedge clk);
            #1;
            check("m2_count", int'(count2), nxt2);
            check("m2_wrap", int'(wrap2), int'(exp_tc2));
            m2 = nxt2;
        end
        en2 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
